// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the RV32I program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int unsigned INSN_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_boot_timer.sv
// Post-reset hold counter: done rises after BOOT_CYCLES counted edges and
// saturates there; with BOOT_CYCLES = 0 done is constant high.
module pc_boot_timer #(
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    output logic done
);

    if (BOOT_CYCLES == 0) begin : g_none
        assign done = 1'b1;
    end else begin : g_count
        localparam int unsigned   CW   = $clog2(BOOT_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(BOOT_CYCLES);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (count_en && (cnt_q != LAST)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign done = (cnt_q == LAST);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with boot hold, debug halt/resume and misaligned-target
// detection. Define PC_TRAP_EN to add trap entry/return and the epc register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter int unsigned          BOOT_CYCLES  = 4,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_address,
    input  logic            halt_req,
    input  logic            resume,
`ifdef PC_TRAP_EN
    input  logic            trap_req,
    input  logic            mret,
    output logic [XLEN-1:0] epc,
`endif
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            running,
    output logic            misaligned,
    output pc_state_e       dbg_state
);

    if (XLEN < 8) begin : g_bad_xlen
        $error("pc_sequencer: XLEN must be at least 8");
    end
    if (!is_aligned(RESET_VECTOR[1:0])) begin : g_bad_reset_vector
        $error("pc_sequencer: RESET_VECTOR must be 4-byte aligned");
    end
    if (!is_aligned(TRAP_VECTOR[1:0])) begin : g_bad_trap_vector
        $error("pc_sequencer: TRAP_VECTOR must be 4-byte aligned");
    end

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inc;
    logic            running_q;
    logic            mis_q, mis_d;
    logic            boot_done;
`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc_q, epc_d;
`endif

    pc_boot_timer #(
        .BOOT_CYCLES(BOOT_CYCLES)
    ) u_boot_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .count_en(state_q == BOOT),
        .done    (boot_done)
    );

    // Wraps modulo 2^XLEN; the carry out is simply dropped.
    assign pc_inc = pc_q + XLEN'(INSN_BYTES);

    // Requests not taken in a cycle are dropped, never queued.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
`ifdef PC_TRAP_EN
        epc_d   = epc_q;
`endif
        unique case (state_q)
            BOOT: begin
                if (boot_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (!enable) begin
                    state_d = RUN;
`ifdef PC_TRAP_EN
                end else if (trap_req) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (mret) begin
                    pc_d  = epc_q;
                    mis_d = 1'b0;
`endif
                end else if (jump && is_aligned(jump_address[1:0])) begin
                    pc_d = jump_address;
                end else if (jump) begin
                    mis_d = 1'b1;
`ifdef PC_TRAP_EN
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
`else
                    state_d = HALT;
`endif
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_d = RUN;
`ifndef PC_TRAP_EN
                    mis_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            running_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            mis_q     <= mis_d;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`endif

    assign pc         = pc_q;
    assign pc_plus4   = pc_inc;
    assign running    = running_q;
    assign misaligned = mis_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (RESET_VECTOR 0x1000,
// BOOT_CYCLES 4); expectations follow PC_TRAP_EN when it is defined.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_1000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        jump;
    logic [31:0] jump_address;
    logic        halt_req;
    logic        resume;
    logic        trap_req;
    logic        mret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        running;
    logic        misaligned;
    logic [1:0]  dbg_state;

    int n_pass;
    int n_total;

    pc_sequencer #(
        .XLEN        (32),
        .RESET_VECTOR(RV),
        .BOOT_CYCLES (4),
        .TRAP_VECTOR (TV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .jump        (jump),
        .jump_address(jump_address),
        .halt_req    (halt_req),
        .resume      (resume),
`ifdef PC_TRAP_EN
        .trap_req    (trap_req),
        .mret        (mret),
        .epc         (epc),
`endif
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .running     (running),
        .misaligned  (misaligned),
        .dbg_state   (dbg_state)
    );

`ifndef PC_TRAP_EN
    assign epc = 32'h0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        en;
        logic        jmp;
        logic [31:0] addr;
        logic        hreq;
        logic        res;
        logic        trp;
        logic        mr;
        logic [31:0] e_pc;
        logic        e_run;
        logic        e_mis;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        enable       = 1'b0;
        jump         = 1'b0;
        jump_address = 32'h0;
        halt_req     = 1'b0;
        resume       = 1'b0;
        trap_req     = 1'b0;
        mret         = 1'b0;
    endtask

    task automatic add(input string name, input logic en, input logic jmp, input logic [31:0] addr,
                       input logic hreq, input logic res, input logic trp, input logic mr,
                       input logic [31:0] e_pc, input logic e_run, input logic e_mis,
                       input logic [31:0] e_epc);
        vec_t v;
        v.name = name; v.en = en; v.jmp = jmp; v.addr = addr; v.hreq = hreq; v.res = res;
        v.trp = trp; v.mr = mr; v.e_pc = e_pc; v.e_run = e_run; v.e_mis = e_mis; v.e_epc = e_epc;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, RV);
        check({tag, "_running"}, {31'h0, running}, 32'h0);
        check({tag, "_misaligned"}, {31'h0, misaligned}, 32'h0);
`ifdef PC_TRAP_EN
        check({tag, "_epc"}, epc, 32'h0);
`endif
    endtask

    // Four hold edges with junk requests, RUN on edge 5, first increment on edge 6.
    task automatic check_boot(input string tag);
        for (int i = 1; i <= 4; i++) begin
            enable = 1'b1; jump = 1'b1; jump_address = 32'h200; halt_req = 1'b1; resume = 1'b1;
            step();
            check($sformatf("%s_boot%0d_running", tag, i), {31'h0, running}, 32'h0);
            check($sformatf("%s_boot%0d_pc", tag, i), pc, RV);
        end
        clear_inputs();
        enable = 1'b1;
        step();
        check({tag, "_boot5_running"}, {31'h0, running}, 32'h1);
        check({tag, "_boot5_pc"}, pc, RV);
        step();
        check({tag, "_boot6_pc"}, pc, RV + 32'h4);
        check({tag, "_boot6_pc_plus4"}, pc_plus4, RV + 32'h8);
        clear_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clear_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("por");
        check("por_pc_plus4", pc_plus4, RV + 32'h4);
        #5 reset_n = 1'b1;

        check_boot("first");

`ifdef PC_TRAP_EN
        add("mis_trap",   1, 1, 32'h202,      0, 0, 0, 0, 32'h100, 1, 1, 32'h40);
`endif
        add("inc",        1, 0, 32'h0,        0, 0, 0, 0, 32'h1008,     1, 0, 32'h0);
        add("jump_stall", 0, 1, 32'h200,      0, 0, 0, 0, 32'h1008,     1, 0, 32'h0);
        add("jump",       1, 1, 32'h200,      0, 0, 0, 0, 32'h200,      1, 0, 32'h0);
        add("jump_top",   1, 1, 32'hFFFF_FFFC,0, 0, 0, 0, 32'hFFFF_FFFC,1, 0, 32'h0);
        add("wrap",       1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 32'h0);
        add("stall",      0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 32'h0);
        add("jump40",     1, 1, 32'h40,       0, 0, 0, 0, 32'h40,       1, 0, 32'h0);
        add("halt_stall", 0, 0, 32'h0,        1, 0, 0, 0, 32'h40,       0, 0, 32'h0);
        add("halt_both",  1, 0, 32'h0,        1, 1, 0, 0, 32'h40,       0, 0, 32'h0);
        add("resume",     1, 1, 32'h300,      0, 1, 0, 0, 32'h40,       1, 0, 32'h0);
`ifdef PC_TRAP_EN
        vecs.delete(0);
        add("mis_jump",   1, 1, 32'h202,      0, 0, 0, 0, 32'h100,      1, 1, 32'h40);
        add("mret",       1, 0, 32'h0,        0, 0, 0, 1, 32'h40,       1, 0, 32'h40);
`else
        add("mis_jump",   1, 1, 32'h202,      0, 0, 0, 0, 32'h40,       0, 1, 32'h0);
        add("mis_resume", 0, 0, 32'h0,        0, 1, 0, 0, 32'h40,       1, 0, 32'h0);
`endif
        add("halt_prio",  1, 1, 32'h300,      1, 0, 0, 0, 32'h40,       0, 0, vecs[vecs.size()-1].e_epc);
        add("resume2",    0, 0, 32'h0,        0, 1, 0, 0, 32'h40,       1, 0, vecs[vecs.size()-1].e_epc);
        add("jump80",     1, 1, 32'h80,       0, 1, 0, 0, 32'h80,       1, 0, vecs[vecs.size()-1].e_epc);
        add("mis_stall",  0, 1, 32'h3,        0, 0, 0, 0, 32'h80,       1, 0, vecs[vecs.size()-1].e_epc);
`ifdef PC_TRAP_EN
        add("trap_prio",  1, 1, 32'h200,      0, 0, 1, 1, 32'h100,      1, 0, 32'h80);
        add("mret2",      1, 1, 32'h300,      0, 0, 0, 1, 32'h80,       1, 0, 32'h80);
        add("trap_stall", 0, 0, 32'h0,        0, 0, 1, 0, 32'h80,       1, 0, 32'h80);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; jump = vecs[i].jmp; jump_address = vecs[i].addr;
            halt_req = vecs[i].hreq; resume = vecs[i].res; trap_req = vecs[i].trp; mret = vecs[i].mr;
            step();
            check({vecs[i].name, "_pc"}, pc, vecs[i].e_pc);
            check({vecs[i].name, "_pc_plus4"}, pc_plus4, vecs[i].e_pc + 32'h4);
            check({vecs[i].name, "_running"}, {31'h0, running}, {31'h0, vecs[i].e_run});
            check({vecs[i].name, "_misaligned"}, {31'h0, misaligned}, {31'h0, vecs[i].e_mis});
`ifdef PC_TRAP_EN
            check({vecs[i].name, "_epc"}, epc, vecs[i].e_epc);
`endif
        end
        clear_inputs();

        // Misaligned jump from 0x80, then halt, then asynchronous reset mid-HALT.
        enable = 1'b1; jump = 1'b1; jump_address = 32'h206;
        step();
        check("mis2_misaligned", {31'h0, misaligned}, 32'h1);
        clear_inputs();
        halt_req = 1'b1;
        step();
        check("halt_before_reset_running", {31'h0, running}, 32'h0);
        check("halt_before_reset_misaligned", {31'h0, misaligned}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("halt_reset");
        #1 reset_n = 1'b1;
        clear_inputs();

        // Two boot edges, then reset mid-BOOT: the boot count must restart.
        step();
        step();
        check("midboot_running", {31'h0, running}, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("boot_reset");
        #1 reset_n = 1'b1;
        check_boot("second");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
